// File: rtl/axis_packet_drop_fifo_pkg.sv
// Shared types and constants for the packet-drop AXI-Stream FIFO.
package axis_packet_drop_fifo_pkg;

  // Write-side packet FSM: IDLE between packets, WR while a packet is being
  // stored, DROP while discarding the remainder of an oversized packet.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  // Width of the saturating dropped-packet counter.
  localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/axis_pkt_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated read. The read register holds its value while re_i is low.
module axis_pkt_sdp_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 37,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/axis_packet_drop_fifo.sv
// Store-and-forward AXI-Stream packet FIFO. Packets become visible to the
// reader only once their tlast beat arrives with tuser=0; errored packets and
// packets larger than the memory are discarded by rewinding the write pointer.
//
// Handshake: a beat transfers on a rising aclk edge where tvalid and tready
// are both 1; a source holds tvalid and its payload until that edge, and the
// output side keeps its payload stable while tvalid=1 and tready=0.
module axis_packet_drop_fifo
  import axis_packet_drop_fifo_pkg::*;
#(
  parameter int DSIZE     = 32,
  parameter int KSIZE     = DSIZE/8,
  parameter int DEPTH     = 512,
  parameter int PKT_DEPTH = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [DSIZE-1:0]               axis_in_tdata,
  input  logic [KSIZE-1:0]               axis_in_tkeep,
  input  logic                           axis_in_tuser,
  input  logic                           axis_in_tlast,
  input  logic                           axis_in_tvalid,
  output logic                           axis_in_tready,
  output logic [DSIZE-1:0]               axis_out_tdata,
  output logic [KSIZE-1:0]               axis_out_tkeep,
  output logic                           axis_out_tlast,
  output logic                           axis_out_tvalid,
  input  logic                           axis_out_tready,
  output logic [$clog2(PKT_DEPTH+1)-1:0] pkt_cnt,
  output logic [DROP_CNT_W-1:0]          drop_cnt,
  output logic                           drop_pulse,
  output logic [1:0]                     wr_state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(PKT_DEPTH+1);
  localparam int MW = DSIZE + KSIZE + 1;

  // wr_ptr: next write slot; cmt_ptr: end of committed data; rd_ptr: words
  // retired through the output handshake (frees memory); raddr: next word
  // fetched from memory into the read pipeline.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, raddr_q, raddr_d;
  wr_state_e     state_q, state_d;
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic          drop_pulse_q;
  logic          ram_vld_q, ram_vld_d;
  logic [DSIZE-1:0] out_data_q;
  logic [KSIZE-1:0] out_keep_q;
  logic          out_last_q, out_vld_q, out_vld_d;
  logic [MW-1:0] ram_rdata;

  logic full, ovf, in_ready, in_fire, out_fire, out_last_fire;
  logic wr_en, commit, drop, rd_en, out_load;

  assign full          = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
  assign ovf           = full && (cmt_ptr_q == rd_ptr_q) && (state_q != ST_DROP);
  assign in_fire       = axis_in_tvalid && in_ready;
  assign out_fire      = out_vld_q && axis_out_tready;
  assign out_last_fire = out_fire && out_last_q;
  assign out_load      = ram_vld_q && (!out_vld_q || axis_out_tready);
  assign rd_en         = (cmt_ptr_q != raddr_q) && (!ram_vld_q || out_load);

  // Input ready: forced low in reset, always high while discarding,
  // otherwise backpressure on a full memory that is still draining or a
  // full packet table.
  always_comb begin
    in_ready = 1'b1;
    if (!aresetn)                                  in_ready = 1'b0;
    else if (state_q == ST_DROP)                   in_ready = 1'b1;
    else if (full && (cmt_ptr_q != rd_ptr_q))      in_ready = 1'b0;
    else if (pkt_cnt_q == CW'(PKT_DEPTH))          in_ready = 1'b0;
  end

  // Write FSM: store, commit or discard incoming beats.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    wr_en     = 1'b0;
    commit    = 1'b0;
    drop      = 1'b0;
    if (state_q == ST_DROP) begin
      if (in_fire && axis_in_tlast) begin
        drop    = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (ovf) begin
      // The packet alone fills the memory: abandon it and swallow the rest.
      wr_ptr_d = cmt_ptr_q;
      if (in_fire && axis_in_tlast) begin
        drop    = 1'b1;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_DROP;
      end
    end else if (in_fire) begin
      if (!axis_in_tlast) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        state_d  = ST_WR;
      end else if (!axis_in_tuser) begin
        wr_en     = 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        cmt_ptr_d = wr_ptr_q + 1'b1;
        commit    = 1'b1;
        state_d   = ST_IDLE;
      end else begin
        wr_ptr_d = cmt_ptr_q;
        drop     = 1'b1;
        state_d  = ST_IDLE;
      end
    end
  end

  // Counters and read-pipeline next state.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (commit && !out_last_fire)      pkt_cnt_d = pkt_cnt_q + 1'b1;
    else if (!commit && out_last_fire) pkt_cnt_d = pkt_cnt_q - 1'b1;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    raddr_d  = rd_en ? raddr_q + 1'b1 : raddr_q;
    rd_ptr_d = out_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ram_vld_d = ram_vld_q;
    if (rd_en)         ram_vld_d = 1'b1;
    else if (out_load) ram_vld_d = 1'b0;
    out_vld_d = out_vld_q;
    if (out_load)             out_vld_d = 1'b1;
    else if (axis_out_tready) out_vld_d = 1'b0;
  end

  // State registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      cmt_ptr_q    <= '0;
      rd_ptr_q     <= '0;
      raddr_q      <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      ram_vld_q    <= 1'b0;
      out_vld_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cmt_ptr_q    <= cmt_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      raddr_q      <= raddr_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      drop_pulse_q <= drop;
      ram_vld_q    <= ram_vld_d;
      out_vld_q    <= out_vld_d;
    end
  end

  // Output payload register, loaded from the RAM read stage.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_data_q <= '0;
      out_keep_q <= '0;
      out_last_q <= 1'b0;
    end else if (out_load) begin
      {out_last_q, out_keep_q, out_data_q} <= ram_rdata;
    end
  end

  axis_pkt_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (MW)
  ) u_ram (
    .clk     (aclk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({axis_in_tlast, axis_in_tkeep, axis_in_tdata}),
    .re_i    (rd_en),
    .raddr_i (raddr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign axis_in_tready  = in_ready;
  assign axis_out_tdata  = out_data_q;
  assign axis_out_tkeep  = out_keep_q;
  assign axis_out_tlast  = out_last_q;
  assign axis_out_tvalid = out_vld_q;
  assign pkt_cnt         = pkt_cnt_q;
  assign drop_cnt        = drop_cnt_q;
  assign drop_pulse      = drop_pulse_q;
  assign wr_state_o      = state_q;

endmodule

// File: doc/axis_packet_drop_fifo.md
AXIS_PACKET_DROP_FIFO -- requirements
Module: axis_packet_drop_fifo

Interface
REQ-001 SHALL have parameter DSIZE, default 32: tdata width in bits.
REQ-002 SHALL have parameter KSIZE, default DSIZE/8: tkeep width in bits.
REQ-003 SHALL have parameter DEPTH, default 512: data memory depth in words; power of two, 16 or more.
REQ-004 SHALL have parameter PKT_DEPTH, default 16: maximum number of committed packets held.
REQ-005 SHALL have ports, one clock and an asynchronous active-low reset:
 - aclk  in  1  the single clock.
 - aresetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have input-side ports:
 - axis_in_tdata  in  DSIZE  data.
 - axis_in_tkeep  in  KSIZE  byte enables.
 - axis_in_tuser  in  1  error flag; sampled on the tlast beat only.
 - axis_in_tlast  in  1  end of packet.
 - axis_in_tvalid  in  1  source valid.
 - axis_in_tready  out  1  sink ready.
REQ-007 SHALL have output-side ports:
 - axis_out_tdata  out  DSIZE  data.
 - axis_out_tkeep  out  KSIZE  byte enables.
 - axis_out_tlast  out  1  end of packet.
 - axis_out_tvalid  out  1  valid.
 - axis_out_tready  in  1  sink ready.
REQ-008 SHALL have status ports:
 - pkt_cnt  out  $clog2(PKT_DEPTH+1)  number of committed, not fully read packets.
 - drop_cnt  out  16  dropped-packet count; saturates at 16'hFFFF.
 - drop_pulse  out  1  one-cycle strobe per dropped packet.

Function
REQ-009 SHALL store tdata, tkeep and tlast per word, so that output tlast comes from memory and not from length tracking.
REQ-010 SHALL operate store-and-forward: a word becomes readable only after its packet's tlast beat is accepted without error.
REQ-011 SHALL keep three pointers (wr_ptr, cmt_ptr, rd_ptr), each $clog2(DEPTH)+1 bits, which wrap modulo 2*DEPTH. Memory is full when wr_ptr-rd_ptr==DEPTH.
REQ-012 SHALL use the write FSM states IDLE, WR and DROP.
REQ-013 In IDLE or WR, an accepted beat with tlast=0 SHALL be written and the FSM SHALL move to WR.
REQ-014 An accepted tlast beat with tuser=0 SHALL be written; the next cycle SHALL have cmt_ptr=wr_ptr after the write and pkt_cnt incremented; the FSM SHALL move to IDLE.
REQ-015 An accepted tlast beat with tuser=1 SHALL NOT be written; wr_ptr SHALL rewind to cmt_ptr, drop_cnt SHALL increment, drop_pulse SHALL be 1, and the FSM SHALL move to IDLE.
REQ-016 When memory is full and cmt_ptr!=rd_ptr (committed data is draining), axis_in_tready SHALL be 0 (backpressure).
REQ-017 When memory is full and cmt_ptr==rd_ptr (the packet is larger than DEPTH), wr_ptr SHALL rewind to cmt_ptr and the FSM SHALL move to DROP.
REQ-018 In DROP, axis_in_tready SHALL be 1 and every beat SHALL be discarded. On the tlast beat, drop_cnt SHALL increment, drop_pulse SHALL be 1, and the FSM SHALL move to IDLE.
REQ-019 In IDLE and WR, axis_in_tready SHALL be 0 while pkt_cnt==PKT_DEPTH.
REQ-020 SHALL register the output stage: a committed word SHALL appear on axis_out_* 2 cycles after the commit cycle.
REQ-021 SHALL sustain one word per cycle while axis_out_tready=1 and committed words remain (prefetch).
REQ-022 Output signals SHALL stay stable while axis_out_tvalid=1 and axis_out_tready=0.
REQ-023 An output handshake with tlast=1 SHALL decrement pkt_cnt. If a commit happens in the same cycle, pkt_cnt SHALL be unchanged.
REQ-024 A simultaneous write and read when full SHALL NOT occur, because tready is evaluated on the current occupancy.
REQ-025 A single-beat packet (tlast on the first beat) SHALL be committed or dropped directly from IDLE.

Reset
REQ-026 On aresetn=0, asynchronously: pointers=0, FSM=IDLE, pkt_cnt=0, drop_cnt=0, drop_pulse=0, axis_out_tvalid=0, axis_out_tlast=0.
REQ-027 axis_in_tready SHALL be 0 while reset is asserted and 1 on the first cycle after release.
REQ-028 A reset mid-packet SHALL discard all stored and partial data; no partial packet is ever emitted.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE/WR/DROP) and the drop_cnt width constant.
REQ-030 One sub-module SHALL be used: axis_pkt_sdp_ram, a simple dual-port RAM of DEPTH x (DSIZE+KSIZE+1) with 1-cycle registered read.

Verification
REQ-031 Three back-to-back 4-beat packets, out_tready=1: the same 12 words appear in order; tlast on words 4, 8 and 12; pkt_cnt peaks at 1 or 2; first output 2 cycles after the first commit.
REQ-032 A 5-beat packet with tuser=1 on tlast, followed by a good 3-beat packet: only the 3 words are emitted; drop_cnt=1; one drop_pulse.
REQ-033 DEPTH=16, a 20-beat packet with the FIFO empty: tready stays 1; the packet is dropped at its tlast; drop_cnt=1; nothing is emitted; pkt_cnt=0.
REQ-034 DEPTH=16 holding a committed 12-beat packet with out_tready=0, then an 8-beat packet: tready goes 0 after 4 beats. Releasing out_tready drains 12 words, then all 8 words are committed and emitted; drop_cnt=0.
REQ-035 PKT_DEPTH=2, three 1-beat packets with out_tready=0: the third waits with tready=0 while pkt_cnt=2. After one output tlast, it is accepted.
REQ-036 aresetn pulsed low in the middle of the second of two packets: all outputs are at reset values; after release, a new 2-beat packet is emitted intact.
